// File: rtl/set_table_wr.sv
// set_table_wr: owner of a small value set of up to DEPTH distinct entries.
// Commands (insert / delete / clear-all / nop) go through a three-step
// IDLE -> LOOKUP -> COMMIT sequence. A separate registered query port reports
// whether a presented value is currently held in the set.
module set_table_wr #(
    parameter  int DEPTH = 8,
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [1:0]       op_code,
    input  logic [WIDTH-1:0] op_data,
    output logic             resp_valid,
    output logic [1:0]       resp_code,
    input  logic [WIDTH-1:0] q_data,
    output logic             q_hit,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOOKUP = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_NOP    = 2'b00,
        OP_INSERT = 2'b01,
        OP_DELETE = 2'b10,
        OP_CLEAR  = 2'b11
    } opCode_t;

    typedef enum logic [1:0] {
        RC_OK       = 2'b00,
        RC_DUP      = 2'b01,
        RC_FULL     = 2'b10,
        RC_NOTFOUND = 2'b11
    } respCode_t;

    // FSM state
    state_t            state_q, state_d;

    // Latched command
    logic [1:0]        opCode_q;
    logic [WIDTH-1:0]  opData_q;
    logic              accept;

    // Table storage
    logic [WIDTH-1:0]  val_q [DEPTH];
    logic [DEPTH-1:0]  vld_q, vld_d;
    logic [CW-1:0]     count_q, count_d;

    // Lookup results, registered between LOOKUP and COMMIT
    logic [DEPTH-1:0]  match_d, match_q;
    logic [IW-1:0]     freeIdx_d, freeIdx_q;
    logic              freeFound_d, freeFound_q;

    // Commit-side controls
    logic              writeEn;
    logic              respValid_q, respValid_d;
    logic [1:0]        respCode_q, respCode_d;

    // Query path
    logic              qHit_q, qHit_d;

    assign accept     = (state_q == S_IDLE) && op_valid;

    assign op_ready   = (state_q == S_IDLE);
    assign resp_valid = respValid_q;
    assign resp_code  = respCode_q;
    assign q_hit      = qHit_q;
    assign count      = count_q;
    assign full       = (count_q == CW'(DEPTH));
    assign empty      = (count_q == '0);

    // State register; a reset mid-command simply abandons the sequence
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: every accepted command walks LOOKUP and COMMIT once
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (op_valid) state_d = S_LOOKUP;
            S_LOOKUP: state_d = S_COMMIT;
            S_COMMIT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Capture the command on the handshake so the requester may drop it
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            opCode_q <= 2'b00;
            opData_q <= '0;
        end else if (accept) begin
            opCode_q <= op_code;
            opData_q <= op_data;
        end
    end

    // Compare the latched value against every valid slot and find the lowest free slot
    always_comb begin
        match_d     = '0;
        freeIdx_d   = '0;
        freeFound_d = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            match_d[i] = vld_q[i] && (val_q[i] == opData_q);
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!vld_q[i]) begin
                freeIdx_d   = IW'(i);
                freeFound_d = 1'b1;
            end
        end
    end

    // Hold the lookup results so COMMIT works from registered values only
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            match_q     <= '0;
            freeIdx_q   <= '0;
            freeFound_q <= 1'b0;
        end else if (state_q == S_LOOKUP) begin
            match_q     <= match_d;
            freeIdx_q   <= freeIdx_d;
            freeFound_q <= freeFound_d;
        end
    end

    // Decide what the commit does to valid bits, count and the response
    always_comb begin
        vld_d       = vld_q;
        count_d     = count_q;
        respCode_d  = respCode_q;
        respValid_d = 1'b0;
        writeEn     = 1'b0;
        if (state_q == S_COMMIT) begin
            respValid_d = 1'b1;
            case (opCode_q)
                OP_INSERT: begin
                    if (|match_q) begin
                        respCode_d = RC_DUP;
                    end else if ((count_q == CW'(DEPTH)) || !freeFound_q) begin
                        respCode_d = RC_FULL;
                    end else begin
                        writeEn           = 1'b1;
                        vld_d[freeIdx_q]  = 1'b1;
                        count_d           = count_q + CW'(1);
                        respCode_d        = RC_OK;
                    end
                end
                OP_DELETE: begin
                    if ((|match_q) && (count_q != '0)) begin
                        vld_d      = vld_q & ~match_q;
                        count_d    = count_q - CW'(1);
                        respCode_d = RC_OK;
                    end else begin
                        respCode_d = RC_NOTFOUND;
                    end
                end
                OP_CLEAR: begin
                    vld_d      = '0;
                    count_d    = '0;
                    respCode_d = RC_OK;
                end
                default: begin
                    respCode_d = RC_OK;
                end
            endcase
        end
    end

    // Valid bits, count and response register; reset empties the set and drops any response
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            vld_q       <= '0;
            count_q     <= '0;
            respValid_q <= 1'b0;
            respCode_q  <= RC_OK;
        end else begin
            vld_q       <= vld_d;
            count_q     <= count_d;
            respValid_q <= respValid_d;
            respCode_q  <= respCode_d;
        end
    end

    // Stored values; only an accepted insert writes a slot, contents of invalid slots are stale
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                val_q[i] <= '0;
            end
        end else if (writeEn) begin
            val_q[freeIdx_q] <= opData_q;
        end
    end

    // Membership test for the query port against the table as it is before this edge
    always_comb begin
        qHit_d = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && (val_q[i] == q_data)) begin
                qHit_d = 1'b1;
            end
        end
    end

    // Registered query result, independent of the command FSM
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            qHit_q <= 1'b0;
        end else begin
            qHit_q <= qHit_d;
        end
    end

endmodule

// File: tb/tb_set_table_wr.sv
// Directed testbench for set_table_wr with hand-computed expectations.
module tb_set_table_wr;

    localparam int DEPTH = 8;
    localparam int WIDTH = 8;
    localparam int CW    = 4;

    localparam logic [1:0] NOP = 2'b00, INS = 2'b01, DEL = 2'b10, CLR = 2'b11;
    localparam logic [1:0] OK  = 2'b00, DUP = 2'b01, FUL = 2'b10, NF  = 2'b11;

    logic             clk = 1'b0;
    logic             clr;
    logic             op_valid;
    logic             op_ready;
    logic [1:0]       op_code;
    logic [WIDTH-1:0] op_data;
    logic             resp_valid;
    logic [1:0]       resp_code;
    logic [WIDTH-1:0] q_data;
    logic             q_hit;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;

    int checks   = 0;
    int failures = 0;

    set_table_wr #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk        (clk),
        .clr        (clr),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op_code    (op_code),
        .op_data    (op_data),
        .resp_valid (resp_valid),
        .resp_code  (resp_code),
        .q_data     (q_data),
        .q_hit      (q_hit),
        .count      (count),
        .full       (full),
        .empty      (empty)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one command and wait (bounded) for its response pulse
    task automatic applyStimulus(input logic [1:0] code, input logic [7:0] data,
                                 output logic [1:0] rc, output int lat);
        int waitCnt;
        waitCnt = 0;
        rc  = 2'bxx;
        lat = -1;
        @(negedge clk);
        while (!op_ready && waitCnt < 20) begin
            @(negedge clk);
            waitCnt++;
        end
        op_valid = 1'b1;
        op_code  = code;
        op_data  = data;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        op_code  = NOP;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (resp_valid) begin
                rc  = resp_code;
                lat = c;
                break;
            end
        end
    endtask

    // Command plus checks on response code and accept-to-response latency
    task automatic runCmd(input string tag, input logic [1:0] code, input logic [7:0] data,
                          input logic [1:0] expRc);
        logic [1:0] rc;
        int         lat;
        applyStimulus(code, data, rc, lat);
        checkOutput({tag, "_rc"}, {30'd0, rc}, {30'd0, expRc});
        checkOutput({tag, "_lat"}, lat, 32'd3);
    endtask

    // Present a query value for one edge and return the registered hit
    task automatic doQuery(input logic [7:0] v, output logic hit);
        @(negedge clk);
        q_data = v;
        @(negedge clk);
        hit = q_hit;
    endtask

    logic       hit;
    int         pulses;
    logic [7:0] fillVals [7];

    initial begin
        fillVals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
        clr      = 1'b1;
        op_valid = 1'b0;
        op_code  = NOP;
        op_data  = '0;
        q_data   = '0;
        repeat (3) @(negedge clk);
        clr = 1'b0;
        @(negedge clk);

        $display("[TB] reset state");
        checkOutput("rst_op_ready", op_ready, 1);
        checkOutput("rst_empty", empty, 1);
        checkOutput("rst_full", full, 0);
        checkOutput("rst_count", count, 0);
        checkOutput("rst_resp_valid", resp_valid, 0);
        checkOutput("rst_resp_code", resp_code, 0);
        doQuery(8'h00, hit);
        checkOutput("rst_q00", hit, 0);

        $display("[TB] first insert");
        runCmd("ins3C", INS, 8'h3C, OK);
        checkOutput("ins3C_count", count, 1);
        checkOutput("ins3C_empty", empty, 0);
        checkOutput("ins3C_ready", op_ready, 1);
        doQuery(8'h3C, hit);
        checkOutput("q3C", hit, 1);
        doQuery(8'h3D, hit);
        checkOutput("q3D", hit, 0);

        $display("[TB] nop leaves table alone");
        runCmd("nop", NOP, 8'h3C, OK);
        checkOutput("nop_count", count, 1);

        $display("[TB] fill to capacity");
        for (int i = 0; i < 7; i++) begin
            runCmd("fill", INS, fillVals[i], OK);
        end
        checkOutput("fill_count", count, 8);
        checkOutput("fill_full", full, 1);
        runCmd("ins9th", INS, 8'h88, FUL);
        checkOutput("ins9th_count", count, 8);
        doQuery(8'h88, hit);
        checkOutput("q88", hit, 0);
        runCmd("insDup", INS, 8'h55, DUP);
        checkOutput("insDup_count", count, 8);

        $display("[TB] delete and reuse");
        runCmd("del22", DEL, 8'h22, OK);
        checkOutput("del22_count", count, 7);
        checkOutput("del22_full", full, 0);
        doQuery(8'h22, hit);
        checkOutput("q22_gone", hit, 0);
        runCmd("del99", DEL, 8'h99, NF);
        checkOutput("del99_count", count, 7);
        runCmd("insA5", INS, 8'hA5, OK);
        checkOutput("insA5_count", count, 8);
        doQuery(8'hA5, hit);
        checkOutput("qA5", hit, 1);
        doQuery(8'h77, hit);
        checkOutput("q77", hit, 1);

        $display("[TB] query on the commit edge");
        @(negedge clk);
        q_data   = 8'h3C;
        op_valid = 1'b1;
        op_code  = DEL;
        op_data  = 8'h3C;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        op_code  = NOP;
        @(negedge clk);
        checkOutput("ce_ready_lookup", op_ready, 0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("ce_resp_valid", resp_valid, 1);
        checkOutput("ce_resp_code", resp_code, OK);
        checkOutput("ce_q_old", q_hit, 1);
        checkOutput("ce_count", count, 7);
        @(negedge clk);
        checkOutput("ce_q_new", q_hit, 0);
        checkOutput("ce_resp_drop", resp_valid, 0);

        $display("[TB] reset mid-command");
        @(negedge clk);
        op_valid = 1'b1;
        op_code  = INS;
        op_data  = 8'hEE;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        op_code  = NOP;
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        pulses = 0;
        repeat (4) begin
            @(negedge clk);
            if (resp_valid) pulses++;
        end
        checkOutput("mid_no_resp", pulses, 0);
        checkOutput("mid_count", count, 0);
        checkOutput("mid_ready", op_ready, 1);
        checkOutput("mid_empty", empty, 1);
        doQuery(8'h77, hit);
        checkOutput("mid_q77", hit, 0);
        runCmd("clrEmpty", CLR, 8'h00, OK);
        checkOutput("clrEmpty_count", count, 0);

        $display("[TB] clear-all on a populated table");
        runCmd("ins01", INS, 8'h01, OK);
        runCmd("ins02", INS, 8'h02, OK);
        checkOutput("two_count", count, 2);
        runCmd("clrAll", CLR, 8'h00, OK);
        checkOutput("clrAll_count", count, 0);
        checkOutput("clrAll_empty", empty, 1);
        doQuery(8'h01, hit);
        checkOutput("clrAll_q01", hit, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
